// File: rtl/imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_stream_loader
// Brief   : Writes a valid/ready stream of instruction words to consecutive
//           IMEM addresses and holds the CPU in reset until loading completes.
// Rev     : 1.0
// ============================================================================
module imem_stream_loader #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 10,
  parameter int BASE_ADDR     = 0,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int                 c_dly_w     = $clog2(RELEASE_DELAY + 1);
  localparam logic [c_dly_w-1:0] c_dly       = c_dly_w'(RELEASE_DELAY);
  localparam logic [c_dly_w-1:0] c_dly_one   = c_dly_w'(1);
  localparam logic [ADDR_W-1:0]  c_base      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  c_last_addr = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_hs;
  logic                w_start_load;
  logic [ADDR_W-1:0]   r_ptr;
  logic [c_dly_w-1:0]  r_cnt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_cpu_rst;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow_err;
  logic [ADDR_W:0]     r_word_count;

  assign in_ready     = (r_state == S_LOAD);
  assign w_hs         = in_valid && in_ready;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign cpu_rst      = r_cpu_rst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign overflow_err = r_overflow_err;
  assign word_count   = r_word_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_start_load = 1'b0;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          w_next       = S_LOAD;
          w_start_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          // A final word at the top address is a legal fit, not an overflow.
          if (in_last) begin
            w_next = S_RELEASE;
          end else if (r_ptr == c_last_addr) begin
            w_next = S_ERROR;
          end
        end
      end
      S_RELEASE: begin
        if (r_cnt == c_dly_one) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr          <= c_base;
      r_cnt          <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= c_base;
      r_wr_data      <= '0;
      r_word_count   <= '0;
      r_cpu_rst      <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_wr_en <= w_hs;
      if (w_hs) begin
        r_wr_addr    <= r_ptr;
        r_wr_data    <= in_data;
        r_word_count <= r_word_count + (ADDR_W + 1)'(1);
        if (r_ptr != c_last_addr) begin
          r_ptr <= r_ptr + ADDR_W'(1);
        end
      end
      if (w_start_load) begin
        r_ptr        <= c_base;
        r_word_count <= '0;
      end
      if (w_hs && in_last) begin
        r_cnt <= c_dly;
      end else if (r_state == S_RELEASE) begin
        r_cnt <= r_cnt - c_dly_one;
      end
      // Status flags follow the state being entered so they line up with it.
      r_cpu_rst      <= (w_next != S_RUN);
      r_busy         <= (w_next == S_LOAD) || (w_next == S_RELEASE);
      r_done         <= (w_next == S_RUN);
      r_overflow_err <= (w_next == S_ERROR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_stream_loader
// Brief   : Randomized self-checking bench for imem_stream_loader (two configs)
// Rev     : 1.0
// ============================================================================
module tb_imem_stream_loader;

  localparam int A_AW = 10, A_BASE = 0, A_DLY = 4;
  localparam int B_AW = 2,  B_BASE = 1, B_DLY = 1;
  localparam int M_IDLE = 0, M_LOAD = 1, M_REL = 2, M_RUN = 3, M_ERR = 4;

  typedef struct {
    int          mode;
    int          words;
    bit          wr_en;
    int          wr_addr;
    logic [31:0] wr_data;
    int          run_at;
  } model_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_start, a_valid, a_last, a_in_ready, a_wr_en, a_cpu_rst, a_busy, a_done, a_ovf;
  logic [31:0] a_data, a_wr_data;
  logic [A_AW-1:0] a_wr_addr;
  logic [A_AW:0]   a_word_count;
  logic        b_start, b_valid, b_last, b_in_ready, b_wr_en, b_cpu_rst, b_busy, b_done, b_ovf;
  logic [31:0] b_data, b_wr_data;
  logic [B_AW-1:0] b_wr_addr;
  logic [B_AW:0]   b_word_count;

  imem_stream_loader #(.DATA_W(32), .ADDR_W(A_AW), .BASE_ADDR(A_BASE), .RELEASE_DELAY(A_DLY)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
    .in_ready(a_in_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .cpu_rst(a_cpu_rst), .busy(a_busy), .done(a_done), .overflow_err(a_ovf), .word_count(a_word_count)
  );

  imem_stream_loader #(.DATA_W(32), .ADDR_W(B_AW), .BASE_ADDR(B_BASE), .RELEASE_DELAY(B_DLY)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .cpu_rst(b_cpu_rst), .busy(b_busy), .done(b_done), .overflow_err(b_ovf), .word_count(b_word_count)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  model_t      ma, mb;
  logic [31:0] prog[$];
  int          gaps[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic model_t m_reset(input int base);
    model_t m;
    m.mode = M_IDLE; m.words = 0; m.wr_en = 1'b0;
    m.wr_addr = base; m.wr_data = '0; m.run_at = -1;
    return m;
  endfunction

  // Behavioural reference: address is base + words so far; release ends a fixed
  // number of cycles after the last handshake.
  function automatic model_t m_step(input model_t m, input bit st, input bit v, input logic [31:0] d,
                                    input bit last, input int base, input int aw, input int dly, input int now);
    model_t n = m;
    n.wr_en = 1'b0;
    if (m.mode == M_LOAD) begin
      if (v) begin
        n.wr_en   = 1'b1;
        n.wr_addr = base + m.words;
        n.wr_data = d;
        n.words   = m.words + 1;
        if (last) begin
          n.mode   = M_REL;
          n.run_at = now + dly;
        end else if (base + n.words == (1 << aw)) begin
          n.mode = M_ERR;
        end
      end
    end else if (m.mode == M_REL) begin
      if (now == m.run_at) n.mode = M_RUN;
    end else if (st) begin
      n.mode  = M_LOAD;
      n.words = 0;
    end
    return n;
  endfunction

  task automatic compare(input string p, input model_t m, input logic ir, input logic we,
                         input logic [63:0] wa, input logic [31:0] wd, input logic cr, input logic bz,
                         input logic dn, input logic ov, input logic [63:0] wc);
    check_eq({p, "in_ready"},   64'(ir), 64'(m.mode == M_LOAD));
    check_eq({p, "wr_en"},      64'(we), 64'(m.wr_en));
    check_eq({p, "wr_addr"},    wa,      64'(m.wr_addr));
    check_eq({p, "wr_data"},    64'(wd), 64'(m.wr_data));
    check_eq({p, "cpu_rst"},    64'(cr), 64'(m.mode != M_RUN));
    check_eq({p, "busy"},       64'(bz), 64'(m.mode == M_LOAD || m.mode == M_REL));
    check_eq({p, "done"},       64'(dn), 64'(m.mode == M_RUN));
    check_eq({p, "overflow"},   64'(ov), 64'(m.mode == M_ERR));
    check_eq({p, "word_count"}, wc,      64'(m.words));
  endtask

  task automatic compare_all();
    compare("a.", ma, a_in_ready, a_wr_en, 64'(a_wr_addr), a_wr_data, a_cpu_rst, a_busy, a_done, a_ovf, 64'(a_word_count));
    compare("b.", mb, b_in_ready, b_wr_en, 64'(b_wr_addr), b_wr_data, b_cpu_rst, b_busy, b_done, b_ovf, 64'(b_word_count));
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (!rst) begin
      ma = m_reset(A_BASE);
      mb = m_reset(B_BASE);
    end else begin
      ma = m_step(ma, a_start, a_valid, a_data, a_last, A_BASE, A_AW, A_DLY, cyc);
      mb = m_step(mb, b_start, b_valid, b_data, b_last, B_BASE, B_AW, B_DLY, cyc);
    end
    #1;
    compare_all();
  endtask

  // Loads prog[] into dut_a with gaps[] idle cycles before each word.
  task automatic load_a(input bit noise);
    int k;
    a_start = 1'b1; cycle(); a_start = 1'b0;
    foreach (prog[i]) begin
      for (int g = 0; g < gaps[i]; g++) begin
        a_valid = 1'b0;
        a_last  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        a_data  = $urandom;
        a_start = noise && ($urandom_range(3, 0) == 0);
        cycle();
      end
      a_valid = 1'b1;
      a_data  = prog[i];
      a_last  = (i == prog.size() - 1);
      a_start = noise && ($urandom_range(3, 0) == 0);
      cycle();
    end
    a_valid = 1'b0; a_last = 1'b0; a_start = 1'b0;
    k = 0;
    while (a_cpu_rst && k < 50) begin
      a_start = noise && (ma.mode == M_REL) && ($urandom_range(1, 0) == 1);
      cycle();
      k++;
    end
    a_start = 1'b0;
    check_eq("a.release_cycles", 64'(k), 64'(A_DLY));
    check_eq("a.done_after_load", 64'(a_done), 64'd1);
    check_eq("a.final_count", 64'(a_word_count), 64'(prog.size()));
  endtask

  task automatic load_b(input int n);
    int k;
    b_start = 1'b1; cycle(); b_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      b_valid = 1'b1; b_data = $urandom; b_last = (i == n - 1);
      cycle();
      if (i == 0) check_eq("b.first_addr", 64'(b_wr_addr), 64'(B_BASE));
    end
    b_valid = 1'b0; b_last = 1'b0;
    k = 0;
    while (!b_done && k < 20) begin cycle(); k++; end
    check_eq("b.release_cycles", 64'(k), 64'(B_DLY));
    check_eq("b.final_count", 64'(b_word_count), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_start = 0; a_valid = 0; a_last = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_last = 0; b_data = '0;
    ma = m_reset(A_BASE);
    mb = m_reset(B_BASE);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 compare_all();
    cycle();
    rst = 1'b1;
    repeat (2) cycle();

    // Back-to-back three-word program.
    prog = '{32'h40008008, 32'h40010007, 32'h0C110000};
    gaps = '{0, 0, 0};
    load_a(1'b0);
    repeat (2) cycle();

    // Same program with valid gaps, reloaded from RUN.
    gaps = '{0, 2, 1};
    load_a(1'b0);

    // One-word reload from RUN.
    prog = '{32'hDEADBEEF};
    gaps = '{0};
    load_a(1'b0);

    // Overflow on the small configuration, then retry and a top-address last word.
    b_start = 1'b1; cycle(); b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_data = $urandom; b_last = 1'b0;
      cycle();
    end
    b_valid = 1'b0;
    cycle();
    check_eq("b.overflow_flag", 64'(b_ovf), 64'd1);
    check_eq("b.overflow_count", 64'(b_word_count), 64'd3);
    check_eq("b.overflow_addr", 64'(b_wr_addr), 64'd3);
    load_b(2);
    load_b(3);
    load_b(1);

    // Randomized programs with start noise during LOAD/RELEASE.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(12, 1);
      prog.delete(); gaps.delete();
      for (int i = 0; i < n; i++) begin
        prog.push_back($urandom);
        gaps.push_back($urandom_range(3, 0));
      end
      load_a(1'b1);
      repeat ($urandom_range(3, 0)) cycle();
    end

    // Asynchronous reset in the middle of a load.
    a_start = 1'b1; cycle(); a_start = 1'b0;
    a_valid = 1'b1; a_data = $urandom; a_last = 1'b0; cycle();
    a_data = $urandom; cycle();
    a_data = $urandom;
    #3 rst = 1'b0;
    #1;
    ma = m_reset(A_BASE);
    mb = m_reset(B_BASE);
    compare_all();
    a_valid = 1'b0;
    cycle();
    rst = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
